// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input; both stages cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, waits for a stable lock,
// releases downstream reset, and tracks timeouts and lock losses.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                fault,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [LOSS_W-1:0]   loss_cnt
);

    localparam int unsigned RST_W = cnt_width(PLL_RST_CYCLES);
    localparam int unsigned STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RST_W-1:0]   RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST    = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    state_e              state_q,   state_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]    stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0]  retry_q,   retry_d;
    logic [LOSS_W-1:0]   loss_q,    loss_d;
    logic                locked_s;

    sync_2ff u_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // State and counter registers; reset returns to the start of a PLL reset pulse.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RESET;
            rst_cnt_q <= '0;
            stb_cnt_q <= '0;
            tmo_cnt_q <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
        end
    end

    // Next-state logic; each counter only advances in its own state and is cleared on entry.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_cnt_d = stb_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;

        unique case (state_q)
            ST_PLL_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    tmo_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d   = ST_STABLE;
                    stb_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    retry_d = retry_q + 1'b1;
                    if (retry_d == RETRY_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d   = ST_PLL_RESET;
                        rst_cnt_d = '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            ST_STABLE: begin
                if (!locked_s) begin
                    state_d   = ST_WAIT_LOCK;
                    tmo_cnt_d = '0;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                // A lock loss takes priority so a coincident relock request still counts once.
                if (!locked_s) begin
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                    state_d   = ST_PLL_RESET;
                    rst_cnt_d = '0;
                end else if (relock_req) begin
                    state_d   = ST_PLL_RESET;
                    rst_cnt_d = '0;
                end
            end

            ST_FAULT: begin
                if (relock_req) begin
                    retry_d   = '0;
                    state_d   = ST_PLL_RESET;
                    rst_cnt_d = '0;
                end
            end

            default: begin
                state_d   = ST_PLL_RESET;
                rst_cnt_d = '0;
            end
        endcase
    end

    // Outputs decoded purely from the registered state.
    always_comb begin
        pll_rst   = (state_q == ST_PLL_RESET);
        ready     = (state_q == ST_RUN);
        sys_rst   = (state_q != ST_RUN);
        fault     = (state_q == ST_FAULT);
        retry_cnt = retry_q;
        loss_cnt  = loss_q;
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with an elapsed-time reference model.
module tb_pll_lock_supervisor;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_STB  = 8;
    localparam int unsigned P_TMO  = 32;
    localparam int unsigned P_MAXR = 2;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TMO),
        .MAX_RETRIES         (P_MAXR)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus the edge at which it was entered; lock seen two edges late.
    int unsigned m_cyc   = 0;
    int unsigned m_enter = 0;
    int          m_phase = PH_RESET;
    int unsigned m_retry = 0;
    int unsigned m_loss  = 0;
    bit          lock_pipe[$] = '{1'b0, 1'b0};
    bit          m_ls;
    int unsigned m_since;

    always @(posedge clk) begin
        m_cyc   = m_cyc + 1;
        m_since = m_cyc - m_enter;
        if (rst) begin
            m_phase   = PH_RESET;
            m_enter   = m_cyc;
            m_retry   = 0;
            m_loss    = 0;
            lock_pipe = '{1'b0, 1'b0};
        end else begin
            m_ls = lock_pipe.pop_front();
            lock_pipe.push_back(pll_locked);
            case (m_phase)
                PH_RESET: if (m_since == P_RST) begin m_phase = PH_WAIT; m_enter = m_cyc; end
                PH_WAIT: begin
                    if (m_ls) begin
                        m_phase = PH_STAB; m_enter = m_cyc;
                    end else if (m_since == P_TMO) begin
                        m_retry = m_retry + 1;
                        m_phase = (m_retry == P_MAXR) ? PH_FAULT : PH_RESET;
                        m_enter = m_cyc;
                    end
                end
                PH_STAB: begin
                    if (!m_ls) begin
                        m_phase = PH_WAIT; m_enter = m_cyc;
                    end else if (m_since == P_STB) begin
                        m_retry = 0; m_phase = PH_RUN; m_enter = m_cyc;
                    end
                end
                PH_RUN: begin
                    if (!m_ls) begin
                        if (m_loss < 255) m_loss = m_loss + 1;
                        m_phase = PH_RESET; m_enter = m_cyc;
                    end else if (relock_req) begin
                        m_phase = PH_RESET; m_enter = m_cyc;
                    end
                end
                default: if (relock_req) begin m_retry = 0; m_phase = PH_RESET; m_enter = m_cyc; end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic [15:0] exp_v;
    logic [15:0] got_v;
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_v = {(m_phase == PH_RESET) ? 1'b1 : 1'b0,
                     (m_phase != PH_RUN)   ? 1'b1 : 1'b0,
                     (m_phase == PH_RUN)   ? 1'b1 : 1'b0,
                     (m_phase == PH_FAULT) ? 1'b1 : 1'b0,
                     m_retry[3:0], m_loss[7:0]};
            got_v = {pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp cyc=%0d got {pll_rst,sys_rst,ready,fault,retry,loss}=%b_%h_%h expected %b_%h_%h",
                         m_cyc, got_v[15:12], got_v[11:8], got_v[7:0], exp_v[15:12], exp_v[11:8], exp_v[7:0]);
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic count_pll_rst_high(output int n);
        n = 0;
        while (pll_rst && n < 100) begin
            n++;
            step(1);
        end
    endtask

    task automatic count_wait_low(output int n);
        n = 0;
        while (!pll_rst && !fault && n < 100) begin
            n++;
            step(1);
        end
    endtask

    task automatic wait_ready(input string name, input int bound, output int n);
        n = 0;
        while (!ready && n < bound) begin
            step(1);
            n++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: ready=0 after %0d cycles, required 1", name, n);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    int n;
    int p;

    initial begin
        rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
        step(2);
        cmp_en = 1'b1;
        step(1);

        // Reset values
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready",   int'(ready),   0);
        chk("rst_fault",   int'(fault),   0);
        chk("rst_retry",   int'(retry_cnt), 0);
        chk("rst_loss",    int'(loss_cnt),  0);

        // Clean bring-up
        rst = 1'b0;
        count_pll_rst_high(n);
        chk("bringup_pll_rst_len", n, 4);
        pll_locked = 1'b1;
        wait_ready("bringup_ready", 40, n);
        chk("bringup_lock_to_ready", n, 11);
        chk("bringup_retry", int'(retry_cnt), 0);

        // One-cycle lock loss in RUN
        step(3);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        n = 1;
        while (!sys_rst && n < 10) begin
            step(1);
            n++;
        end
        chk("loss_detect_latency", n, 3);
        chk("loss_cnt_1", int'(loss_cnt), 1);
        chk("loss_ready_low", int'(ready), 0);
        count_pll_rst_high(n);
        chk("loss_pll_rst_len", n, 4);
        wait_ready("loss_recover", 40, n);

        // Lock loss and relock request seen in the same RUN cycle
        step(2);
        pll_locked = 1'b0;
        step(2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        pll_locked = 1'b1;
        chk("coincident_loss_cnt", int'(loss_cnt), 2);
        count_pll_rst_high(n);
        chk("coincident_pll_rst_len", n, 4);

        // Reset asserted mid-STABLE
        step(3);
        rst = 1'b1;
        step(1);
        chk("midrst_pll_rst", int'(pll_rst), 1);
        chk("midrst_sys_rst", int'(sys_rst), 1);
        chk("midrst_ready",   int'(ready),   0);
        chk("midrst_loss",    int'(loss_cnt), 0);

        // One timeout, then a lock glitch in STABLE
        pll_locked = 1'b0;
        step(1);
        rst = 1'b0;
        count_pll_rst_high(n);
        count_wait_low(n);
        chk("timeout_wait_len", n, 32);
        chk("timeout_retry_1", int'(retry_cnt), 1);
        count_pll_rst_high(n);
        pll_locked = 1'b1;
        step(6);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("glitch_retry_kept", int'(retry_cnt), 1);
        chk("glitch_ready_low", int'(ready), 0);
        wait_ready("glitch_recover", 40, n);
        chk("glitch_to_ready", n, 9);
        chk("glitch_retry_cleared", int'(retry_cnt), 0);

        // Retries exhausted
        rst = 1'b1;
        pll_locked = 1'b0;
        step(2);
        rst = 1'b0;
        count_pll_rst_high(n);
        chk("fault_pulse1_len", n, 4);
        count_wait_low(n);
        chk("fault_wait1_len", n, 32);
        count_pll_rst_high(n);
        chk("fault_pulse2_len", n, 4);
        count_wait_low(n);
        chk("fault_wait2_len", n, 32);
        chk("fault_flag", int'(fault), 1);
        chk("fault_retry_2", int'(retry_cnt), 2);
        step(40);
        chk("fault_held", int'(fault), 1);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk("fault_clear_fault", int'(fault), 0);
        chk("fault_clear_pll_rst", int'(pll_rst), 1);
        chk("fault_clear_retry", int'(retry_cnt), 0);

        // Loss counter saturation
        pll_locked = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_ready("sat_ready", 60, n);
            pll_locked = 1'b0;
            step(1);
            pll_locked = 1'b1;
            step(3);
        end
        wait_ready("sat_final_ready", 60, n);
        chk("loss_saturated", int'(loss_cnt), 255);

        // Randomised segments
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(5))
                0:       p = 0;
                1:       p = 60;
                2:       p = 97;
                default: p = 100;
            endcase
            for (int c = 0; c < 50; c++) begin
                pll_locked = ($urandom_range(99) < p);
                relock_req = ($urandom_range(99) < 3);
                rst        = ($urandom_range(999) < 5);
                step(1);
            end
        end
        rst = 1'b0;
        relock_req = 1'b0;
        step(2);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held per reset attempt (>=2).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (>=2).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum cycles spent waiting for lock per attempt (>=2).
REQ-004 SHALL have parameter MAX_RETRIES, default 7: timed-out attempts tolerated before fault (1..15).
REQ-005 SHALL have port refclk, input, 1: single clock; the free-running PLL reference clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous to refclk, active-high.
REQ-007 SHALL have port pll_locked, input, 1: raw PLL lock flag, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1: single-cycle request to restart the PLL.
REQ-009 SHALL have port pll_rst, output, 1: reset to the PLL, active-high.
REQ-010 SHALL have port sys_rst, output, 1: downstream logic reset, active-high.
REQ-011 SHALL have port ready, output, 1: PLL is locked and stable.
REQ-012 SHALL have port fault, output, 1: retries exhausted.
REQ-013 SHALL have port retry_cnt, output, 4: timed-out attempts since the last success or clear.
REQ-014 SHALL have port loss_cnt, output, 8: lock losses while in RUN; saturates at 255.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer; locked_s is the sync output, 2 cycles of latency.
REQ-016 SHALL implement states PLL_RESET, WAIT_LOCK, STABLE, RUN, FAULT.
REQ-017 Outputs SHALL be decoded from registered state only: pll_rst=1 only in PLL_RESET; ready=1 and sys_rst=0 only in RUN; fault=1 only in FAULT; sys_rst=1 in all other states.
REQ-018 In PLL_RESET, after PLL_RST_CYCLES cycles, the block SHALL go to WAIT_LOCK with the timeout counter cleared.
REQ-019 In WAIT_LOCK, locked_s=1 SHALL move to STABLE with the stable counter cleared.
REQ-020 In WAIT_LOCK, if locked_s stays 0 for LOCK_TIMEOUT_CYCLES cycles, retry_cnt SHALL increment; if the new value equals MAX_RETRIES, go to FAULT, else go to PLL_RESET.
REQ-021 In STABLE, locked_s=0 SHALL return to WAIT_LOCK without retry increment; the timeout counter restarts.
REQ-022 In STABLE, the block SHALL enter RUN after LOCK_STABLE_CYCLES consecutive cycles of locked_s=1, and clear retry_cnt.
REQ-023 In RUN, locked_s=0 SHALL increment loss_cnt (saturating) and go to PLL_RESET.
REQ-024 In RUN, relock_req=1 SHALL go to PLL_RESET without incrementing loss_cnt.
REQ-025 When locked_s drops and relock_req=1 arrive in the same RUN cycle, loss_cnt SHALL increment exactly once, with a single PLL_RESET entry.
REQ-026 In FAULT, the block SHALL hold until relock_req=1, then clear retry_cnt and go to PLL_RESET.
REQ-027 relock_req SHALL be ignored in PLL_RESET, WAIT_LOCK and STABLE.
REQ-028 Counters SHALL be sized by $clog2 of their parameter; no wrap beyond terminal values.

Reset
REQ-029 While rst=1 at a refclk edge: state=PLL_RESET with cycle counter 0, synchronizer flops 0, retry_cnt=0, loss_cnt=0.
REQ-030 Outputs during and after rst: pll_rst=1, sys_rst=1, ready=0, fault=0.
REQ-031 rst asserted mid-operation (any state) SHALL abort immediately to the REQ-029 condition, and loss_cnt SHALL be cleared.

Structure
REQ-032 A shared package SHALL hold the state enum type and counter-width functions.
REQ-033 The synchronizer SHALL be a sub-module, sync_2ff, instantiated once.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-034 Release rst, then raise pll_locked after pll_rst falls -> pll_rst high exactly 4 cycles; ready rises exactly 10 cycles after pll_locked first sampled high; retry_cnt=0.
REQ-035 Keep pll_locked=0 -> two pll_rst pulses of 4 cycles, each followed by 32 cycles of waiting; fault=1 and retry_cnt=2 thereafter; relock_req -> fault=0, pll_rst=1 next cycle.
REQ-036 In RUN, drop pll_locked for 1 cycle -> loss_cnt=1, sys_rst=1 and ready=0 within 3 cycles, pll_rst pulses for 4 cycles.
REQ-037 In STABLE, toggle pll_locked low at stable count 5 -> returns to WAIT_LOCK, retry_cnt unchanged, ready only after 8 fresh consecutive cycles.
REQ-038 In RUN, assert relock_req and drop pll_locked in the same cycle -> loss_cnt +1 exactly; assert rst mid-STABLE -> all outputs at reset values next cycle.
REQ-039 Force 256 losses -> loss_cnt holds at 255.
